// File: rtl/tmds_encoder_multi.sv
// tmds_encoder_multi
//   Pipelined TMDS encoder for NUM_CH independent channels (HDMI/DVI).
//   Stage 1 does the transition-minimisation step. Stage 2 does DC balancing
//   against a per-channel running disparity tally and registers the 10-bit
//   symbol.
//
// Ports
//   clk_in      pixel clock; all state updates on the rising edge
//   rst_n_in    asynchronous active-low reset; clears every register
//   valid_in    qualifies data_in / control_in / ve_in for this cycle
//   ve_in       1 = encode pixel data, 0 = emit control token
//   data_in     channel i byte at [8*i +: 8]
//   control_in  channel i {C1,C0} at [2*i +: 2]
//   tmds_out    channel i symbol at [10*i +: 10]; bit 0 is serialised first
//   valid_out   tmds_out carries a new symbol this cycle
//
// Handshake: valid-only, with no ready and no backpressure. A beat is accepted
// on every rising edge where valid_in=1. It leaves two edges later with
// valid_out=1. A cycle with valid_in=0 is a bubble. It travels down the pipe
// in order, does not load either data register, does not touch the tally,
// and leaves tmds_out holding its previous symbol.

module tmds_encoder_multi #(
  parameter int NUM_CH = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  valid_in,
  input  logic                  ve_in,
  input  logic [8*NUM_CH-1:0]   data_in,
  input  logic [2*NUM_CH-1:0]   control_in,
  output logic [10*NUM_CH-1:0]  tmds_out,
  output logic                  valid_out
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Transition minimisation. XNOR chaining is chosen for bytes with many
  // ones so that the chained word has fewer transitions. q[8] records the
  // choice, with 1 meaning XOR.
  function automatic logic [8:0] tm_encode(input logic [7:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n        = popcount8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(d[i] ^ q[i-1]) : (d[i] ^ q[i-1]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  // ---------------- stage 1 ----------------
  logic [NUM_CH-1:0][8:0] s1_q_d;
  logic [NUM_CH-1:0][3:0] s1_n1_d;

  always_comb begin
    s1_q_d  = '0;
    s1_n1_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      s1_q_d[ch]  = tm_encode(data_in[8*ch +: 8]);
      s1_n1_d[ch] = popcount8(s1_q_d[ch][7:0]);
    end
  end

  logic                   s1_valid;
  logic                   s1_ve;
  logic [NUM_CH-1:0][8:0] s1_q;
  logic [NUM_CH-1:0][3:0] s1_n1;
  logic [2*NUM_CH-1:0]    s1_ctrl;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid <= 1'b0;
      s1_ve    <= 1'b0;
      s1_q     <= '0;
      s1_n1    <= '0;
      s1_ctrl  <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_ve   <= ve_in;
        s1_q    <= s1_q_d;
        s1_n1   <= s1_n1_d;
        s1_ctrl <= control_in;
      end
    end
  end

  // ---------------- stage 2 ----------------
  // cnt is a two's-complement 5-bit tally. Its magnitude stays within 8, so
  // plain 5-bit wrap-around arithmetic is exact.
  logic [NUM_CH-1:0][9:0] sym_d;
  logic [NUM_CH-1:0][4:0] cnt_d;
  logic [NUM_CH-1:0][4:0] cnt_q;

  always_comb begin : stage2_comb
    logic [8:0] q;
    logic       q8;
    logic [4:0] n1;
    logic [4:0] n0;
    logic [4:0] diff;  // N1 - N0
    logic [4:0] cnt;
    sym_d = '0;
    cnt_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      q    = s1_q[ch];
      q8   = q[8];
      n1   = {1'b0, s1_n1[ch]};
      n0   = 5'd8 - n1;
      diff = n1 - n0;
      cnt  = cnt_q[ch];
      if (!s1_ve) begin
        case (s1_ctrl[2*ch +: 2])
          2'b00:   sym_d[ch] = 10'b1101010100;
          2'b01:   sym_d[ch] = 10'b0010101011;
          2'b10:   sym_d[ch] = 10'b0101010100;
          default: sym_d[ch] = 10'b1010101011;
        endcase
        cnt_d[ch] = 5'd0;
      end else if ((cnt == 5'd0) || (s1_n1[ch] == 4'd4)) begin
        sym_d[ch] = {~q8, q8, (q8 ? q[7:0] : ~q[7:0])};
        cnt_d[ch] = q8 ? (cnt + diff) : (cnt - diff);
      end else if ((!cnt[4] && (s1_n1[ch] > 4'd4)) ||
                   ( cnt[4] && (s1_n1[ch] < 4'd4))) begin
        // Tally already leans the same way as this word: invert the word.
        sym_d[ch] = {1'b1, q8, ~q[7:0]};
        cnt_d[ch] = cnt + {3'b000, q8, 1'b0} - diff;
      end else begin
        sym_d[ch] = {1'b0, q8, q[7:0]};
        cnt_d[ch] = cnt + diff - {3'b000, ~q8, 1'b0};
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out <= 1'b0;
      tmds_out  <= '0;
      cnt_q     <= '0;
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        tmds_out <= sym_d;
        cnt_q    <= cnt_d;
      end
    end
  end

endmodule
